// File: rtl/mips_operand_fetch.sv
// Decode / operand-fetch stage: 32x32 register file with writeback bypass,
// instruction decode into ALU operands and control, and the ID/EX register.
module mips_operand_fetch #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_valid,
  input  logic [31:0]       instruction,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_enable,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] content1,
  output logic [DATA_W-1:0] content2,
  output logic [2:0]        ALUControlBit,
  output logic [4:0]        dest_reg,
  output logic              reg_write,
  output logic              ex_valid,
  output logic              illegal_instr
);

  // Handshake: instr_valid qualifies instruction on the edge it is sampled;
  // there is no ready. stall holds the ID/EX register, flush empties it, and
  // flush wins. The writeback port ignores both.

  logic [DATA_W-1:0] rf_q [32];
  logic [DATA_W-1:0] rf_d [32];
  logic              wb_we;

  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;

  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] shamt_ext;

  logic [DATA_W-1:0] dec_c1;
  logic [DATA_W-1:0] dec_c2;
  logic [2:0]        dec_alu;
  logic [4:0]        dec_dest;
  logic              dec_rw;
  logic              dec_ill;

  logic [DATA_W-1:0] content1_q, content1_d;
  logic [DATA_W-1:0] content2_q, content2_d;
  logic [2:0]        alu_ctrl_q, alu_ctrl_d;
  logic [4:0]        dest_reg_q, dest_reg_d;
  logic              reg_write_q, reg_write_d;
  logic              ex_valid_q, ex_valid_d;
  logic              illegal_q, illegal_d;

  assign opcode    = instruction[31:26];
  assign rs        = instruction[25:21];
  assign rt        = instruction[20:16];
  assign rd        = instruction[15:11];
  assign shamt     = instruction[10:6];
  assign funct     = instruction[5:0];
  assign imm       = instruction[15:0];
  assign imm_sext  = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zext  = {{(DATA_W-16){1'b0}}, imm};
  assign shamt_ext = {{(DATA_W-5){1'b0}}, shamt};

  assign wb_we = wb_enable && (wb_addr != 5'd0);

  always_comb begin
    rf_d = rf_q;
    if (wb_we) rf_d[wb_addr] = wb_data;
  end

  // $0 reads as zero regardless of bypass; otherwise same-cycle writes win.
  always_comb begin
    rs_val = rf_q[rs];
    if (rs == 5'd0)                    rs_val = '0;
    else if (wb_we && (wb_addr == rs)) rs_val = wb_data;
    rt_val = rf_q[rt];
    if (rt == 5'd0)                    rt_val = '0;
    else if (wb_we && (wb_addr == rt)) rt_val = wb_data;
  end

  always_comb begin
    dec_c1   = rs_val;
    dec_c2   = rt_val;
    dec_alu  = 3'b000;
    dec_dest = rt;
    dec_rw   = 1'b1;
    dec_ill  = 1'b0;
    case (opcode)
      6'b000000: begin
        dec_dest = rd;
        case (funct)
          6'b100000: dec_alu = 3'b010;
          6'b100010: dec_alu = 3'b110;
          6'b100100: dec_alu = 3'b000;
          6'b100101: dec_alu = 3'b001;
          6'b100110: dec_alu = 3'b011;
          6'b101010: dec_alu = 3'b111;
          6'b000000: begin
            dec_alu = 3'b100;
            dec_c1  = rt_val;
            dec_c2  = shamt_ext;
          end
          6'b000010: begin
            dec_alu = 3'b101;
            dec_c1  = rt_val;
            dec_c2  = shamt_ext;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      6'b001000: begin dec_alu = 3'b010; dec_c2 = imm_sext; end
      6'b001010: begin dec_alu = 3'b111; dec_c2 = imm_sext; end
      6'b001100: begin dec_alu = 3'b000; dec_c2 = imm_zext; end
      6'b001101: begin dec_alu = 3'b001; dec_c2 = imm_zext; end
      6'b000100: begin dec_alu = 3'b110; dec_rw = 1'b0; end
      default:   dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_c1   = '0;
      dec_c2   = '0;
      dec_alu  = 3'b000;
      dec_dest = 5'd0;
      dec_rw   = 1'b0;
    end
  end

  always_comb begin
    content1_d  = content1_q;
    content2_d  = content2_q;
    alu_ctrl_d  = alu_ctrl_q;
    dest_reg_d  = dest_reg_q;
    reg_write_d = reg_write_q;
    ex_valid_d  = ex_valid_q;
    illegal_d   = illegal_q;
    if (flush) begin
      reg_write_d = 1'b0;
      ex_valid_d  = 1'b0;
      illegal_d   = 1'b0;
    end else if (!stall) begin
      content1_d  = dec_c1;
      content2_d  = dec_c2;
      alu_ctrl_d  = dec_alu;
      dest_reg_d  = dec_dest;
      reg_write_d = instr_valid && dec_rw;
      ex_valid_d  = instr_valid;
      illegal_d   = instr_valid && dec_ill;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      content1_q  <= '0;
      content2_q  <= '0;
      alu_ctrl_q  <= 3'b000;
      dest_reg_q  <= 5'd0;
      reg_write_q <= 1'b0;
      ex_valid_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      rf_q        <= rf_d;
      content1_q  <= content1_d;
      content2_q  <= content2_d;
      alu_ctrl_q  <= alu_ctrl_d;
      dest_reg_q  <= dest_reg_d;
      reg_write_q <= reg_write_d;
      ex_valid_q  <= ex_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign content1      = content1_q;
  assign content2      = content2_q;
  assign ALUControlBit = alu_ctrl_q;
  assign dest_reg      = dest_reg_q;
  assign reg_write     = reg_write_q;
  assign ex_valid      = ex_valid_q;
  assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_mips_operand_fetch.sv
// Bench for mips_operand_fetch: directed plan plus random traffic, with a
// queue-based scoreboard fed by an instruction-level reference model.
module tb_mips_operand_fetch;

  localparam int EXP_W = 75;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        stall;
  logic        flush;
  logic        wb_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] content1;
  logic [31:0] content2;
  logic [2:0]  ALUControlBit;
  logic [4:0]  dest_reg;
  logic        reg_write;
  logic        ex_valid;
  logic        illegal_instr;

  int checks = 0;
  int errors = 0;

  // {ex_valid, reg_write, illegal, alu[2:0], dest[4:0], c1[31:0], c2[31:0]}
  logic [EXP_W-1:0] exp_q[$];

  logic [31:0] m_rf [32];
  logic [31:0] m_c1, m_c2;
  logic [2:0]  m_alu;
  logic [4:0]  m_dest;
  logic        m_rw, m_ev, m_ill;

  mips_operand_fetch #(.DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid),
    .instruction(instruction), .stall(stall), .flush(flush),
    .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
    .content1(content1), .content2(content2), .ALUControlBit(ALUControlBit),
    .dest_reg(dest_reg), .reg_write(reg_write), .ex_valid(ex_valid),
    .illegal_instr(illegal_instr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mread(input logic [4:0] r, input logic wen,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (wen && wa == r) return wd;
    return m_rf[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_c1 = 0; m_c2 = 0; m_alu = 0; m_dest = 0; m_rw = 0; m_ev = 0; m_ill = 0;
  endtask

  task automatic model_step(input logic iv, input logic [31:0] ins, input logic st,
                            input logic fl, input logic wen, input logic [4:0] wa,
                            input logic [31:0] wd);
    logic [31:0] a, b, vs, vt;
    logic [2:0]  alu;
    logic [4:0]  dst;
    logic        rw, ok;
    int          op, fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    vs = mread(ins[25:21], wen, wa, wd);
    vt = mread(ins[20:16], wen, wa, wd);
    a = vs; b = vt; alu = 0; dst = ins[20:16]; rw = 1; ok = 1;
    if (op == 0) begin
      dst = ins[15:11];
      case (fn)
        32: alu = 2;
        34: alu = 6;
        36: alu = 0;
        37: alu = 1;
        38: alu = 3;
        42: alu = 7;
        0, 2: begin
          alu = (fn == 0) ? 3'd4 : 3'd5;
          a = vt;
          b = 32'(ins[10:6]);
        end
        default: ok = 0;
      endcase
    end else if (op == 8 || op == 10) begin
      alu = (op == 8) ? 3'd2 : 3'd7;
      b = 32'($signed(ins[15:0]));
    end else if (op == 12 || op == 13) begin
      alu = (op == 12) ? 3'd0 : 3'd1;
      b = 32'(ins[15:0]);
    end else if (op == 4) begin
      alu = 6;
      rw = 0;
    end else begin
      ok = 0;
    end
    if (!ok) begin a = 0; b = 0; alu = 0; rw = 0; end
    if (fl) begin
      m_ev = 0; m_rw = 0; m_ill = 0;
    end else if (!st) begin
      m_c1 = a; m_c2 = b; m_alu = alu; m_dest = dst;
      m_ev = iv; m_rw = iv && rw; m_ill = iv && !ok;
    end
    if (wen && wa != 0) m_rf[wa] = wd;
    exp_q.push_back({m_ev, m_rw, m_ill, m_alu, m_dest, m_c1, m_c2});
  endtask

  // ---------------- driver ----------------
  task automatic apply(input logic iv, input logic [31:0] ins, input logic st,
                       input logic fl, input logic wen, input logic [4:0] wa,
                       input logic [31:0] wd);
    instr_valid = iv; instruction = ins; stall = st; flush = fl;
    wb_enable = wen; wb_addr = wa; wb_data = wd;
    model_step(iv, ins, st, fl, wen, wa, wd);
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic st,
                       input logic fl, input logic wen, input logic [4:0] wa,
                       input logic [31:0] wd);
    @(negedge clk);
    apply(iv, ins, st, fl, wen, wa, wd);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_content1"}, content1, 32'd0);
    chk({tag, "_content2"}, content2, 32'd0);
    chk({tag, "_alu"}, 32'(ALUControlBit), 32'd0);
    chk({tag, "_dest"}, 32'(dest_reg), 32'd0);
    chk({tag, "_reg_write"}, 32'(reg_write), 32'd0);
    chk({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal_instr), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 8) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  fns [9];
    logic [5:0]  ops [8];
    logic [5:0]  bad [4];
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd42, 6'd0, 6'd2, 6'd39};
    ops = '{6'd8, 6'd10, 6'd12, 6'd13, 6'd4, 6'd0, 6'd0, 6'd0};
    bad = '{6'h3f, 6'h02, 6'h23, 6'h2b};
    w = $urandom;
    if ($urandom_range(0, 9) == 0) w[31:26] = bad[$urandom_range(0, 3)];
    else w[31:26] = ops[$urandom_range(0, 7)];
    if (w[31:26] == 6'd0) w[5:0] = fns[$urandom_range(0, 8)];
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ex_valid", 32'(ex_valid), 32'(e[74]));
        chk("reg_write", 32'(reg_write), 32'(e[73]));
        chk("illegal_instr", 32'(illegal_instr), 32'(e[72]));
        if (e[74]) begin
          chk("alu_ctrl", 32'(ALUControlBit), 32'(e[71:69]));
          chk("content1", content1, e[63:32]);
          chk("content2", content2, e[31:0]);
          if (e[73]) chk("dest_reg", 32'(dest_reg), 32'(e[68:64]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    instr_valid = 0; instruction = 0; stall = 0; flush = 0;
    wb_enable = 0; wb_addr = 0; wb_data = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0);

    // basic R-type
    drive(0, 32'h0, 0, 0, 1, 5'd8, 32'd15);
    drive(0, 32'h0, 0, 0, 1, 5'd9, 32'd5);
    drive(1, 32'h01095020, 0, 0, 0, 0, 0);
    // same-cycle bypass
    drive(1, 32'h01095022, 0, 0, 1, 5'd8, 32'hFFFFFFFD);
    // immediates, shifts, branch
    drive(1, 32'h2109FFFD, 0, 0, 0, 0, 0);
    drive(1, 32'h3109FFFD, 0, 0, 0, 0, 0);
    drive(1, 32'h2909FFFD, 0, 0, 0, 0, 0);
    drive(1, 32'h3509FFFD, 0, 0, 0, 0, 0);
    drive(1, 32'h00085082, 0, 0, 0, 0, 0);
    drive(1, 32'h11090003, 0, 0, 0, 0, 0);
    // $0 hardwiring and illegal opcode/funct
    drive(1, 32'h00000825, 0, 0, 1, 5'd0, 32'h1234);
    drive(1, 32'h00000825, 0, 0, 0, 0, 0);
    drive(1, 32'hFC000000, 0, 0, 0, 0, 0);
    drive(1, 32'h01095027, 0, 0, 0, 0, 0);
    // stall hold with writes to sources, then flush+stall
    drive(1, 32'h01095020, 0, 0, 0, 0, 0);
    drive(1, 32'h2109FFFD, 1, 0, 1, 5'd8, 32'd77);
    drive(1, 32'h3109FFFD, 1, 0, 1, 5'd9, 32'd88);
    drive(1, 32'hFC000000, 1, 0, 1, 5'd8, 32'd99);
    drive(1, 32'h01095020, 1, 1, 0, 0, 0);
    drive(0, 32'h01095020, 0, 0, 0, 0, 0);
    drive(1, 32'h01095020, 0, 0, 0, 0, 0);

    // asynchronous reset between edges while ex_valid is high
    @(posedge clk); #3;
    chk("pre_reset_ex_valid", 32'(ex_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h01095020, 0, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 4) != 0, rand_instr(),
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
